data_store: RTL
===============

# data_store

Data-load stage directly downstream of the instruction/data header decoder. While the decoder is in its data phase it presents FIFO words via `ds_empty_n`. This block pops them with `ds_read` and writes each 64-bit beat into the on-chip buffer SRAM at consecutive addresses from a programmed base. It counts beats, enforces a word limit, and pulses `load_done` when the beat carrying `fifo_last_din` has been written.

## Interface
Parameters:
- `TBITS`, 64, data beat width
- `TBYTE`, 8, strobe width (`TBITS/8`)
- `ADDR_W`, 12, buffer word-address width

Ports:
- `clk`  input  1  single clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `ds_empty_n`  input  1  upstream has a valid beat (high only during upstream data phase)
- `ds_read`  output  1  pop request; a beat transfers when `ds_empty_n && ds_read`
- `fifo_data_din`  input  TBITS  beat data
- `fifo_strb_din`  input  TBYTE  beat byte strobes
- `fifo_last_din`  input  1  final beat of the DMA transfer
- `base_addr`  input  ADDR_W  first buffer address, sampled at load start
- `wr_limit`  input  ADDR_W+1  maximum beats to store; 0 means no limit
- `mem_en`  output  1  SRAM access strobe
- `mem_we`  output  TBYTE  SRAM byte write enables
- `mem_addr`  output  ADDR_W  SRAM word address
- `mem_wdata`  output  TBITS  SRAM write data
- `load_busy`  output  1  high in LOAD
- `load_done`  output  1  one-cycle pulse at end of transfer
- `word_cnt`  output  ADDR_W+1  beats accepted in the current or last load
- `ovf_err`  output  1  sticky: beats arrived beyond `wr_limit`

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE**
  - `ds_read`=0.
  - When `ds_empty_n`=1: latch `base_addr` into the write pointer, clear `word_cnt` and `ovf_err`, then go to LOAD.
  - The transition costs one bubble cycle, by design.
- **LOAD**
  - `ds_read`=1 unconditionally; the block never stalls upstream.
  - On each beat:
    - If `wr_limit`==0 or `word_cnt` < `wr_limit`: schedule an SRAM write of the beat at the pointer, increment the pointer, increment `word_cnt`.
    - Otherwise: discard the beat (no SRAM access, pointer and `word_cnt` held) and set `ovf_err`.
  - On a beat with `fifo_last_din`=1, go to DONE, whether that beat was stored or discarded.
- **DONE**: assert `load_done` for one cycle, then go to IDLE.
- The pointer wraps from 2^ADDR_W−1 to 0 without error.
- `word_cnt` saturates at 2^(ADDR_W+1)−1.
- `word_cnt` and `ovf_err` hold their values after DONE until the next load start.
- Outside LOAD, the input data, strobe and last signals are ignored.

## Timing
- Reset values: `ds_read`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `load_busy`=0, `load_done`=0, `word_cnt`=0, `ovf_err`=0, state IDLE.
- `ds_read` is combinational from state only. It has no combinational path from `ds_empty_n`.
- SRAM outputs are registered with one-cycle latency: a beat accepted at edge N produces `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` valid during cycle N+1.
- `mem_en`=0 and `mem_we`=0 on every cycle without a scheduled write.
- `load_done` is high in the cycle after the last beat is accepted, coincident with that beat's SRAM write.
- Upstream leaves its data phase on that same last beat, so `ds_empty_n` falls with no extra pops.
- `ovf_err` updates in the cycle after the offending beat.
- Back-to-back beats are accepted every cycle, giving full throughput.
- Reset mid-LOAD: all outputs return to reset values on the next edge. A pending SRAM write is dropped.

## Configuration
- Macro `DS_STRB_EN`:
  - Defined: `mem_we` is the registered `fifo_strb_din` of the beat. A beat with strobe 0 is still counted and still advances the pointer, but drives `mem_en`=1 with `mem_we`=0.
  - Undefined: the strobe input is ignored and `mem_we` = all ones on every write.

## Test plan
- Reset, base 0x010, limit 0, 4 consecutive beats D0..D3 with last on D3:
  - Writes appear at 0x010..0x013 one cycle after each beat.
  - `load_done` pulses with the D3 write.
  - `word_cnt`=4, `ovf_err`=0.
- `ds_empty_n` toggling every other cycle, 3 beats:
  - Exactly 3 writes, with addresses contiguous.
  - No write in any gap cycle.
- Base 0xFFE, 4 beats:
  - Addresses 0xFFE, 0xFFF, 0x000, 0x001.
  - `ovf_err`=0.
- Limit 2, 5 beats with last on beat 5:
  - Only 2 writes occur.
  - All 5 beats are popped.
  - `ovf_err`=1 from the cycle after beat 3.
  - `load_done` pulses after beat 5.
  - `word_cnt`=2.
- Reset asserted in the cycle after beat 2 of 6:
  - All outputs return to 0.
  - Beat 2's write is not issued.
  - The next `ds_empty_n` starts a fresh load with `word_cnt` cleared.
- With `DS_STRB_EN`, beat strobe 0x0F:
  - `mem_we`=0x0F.
  - Without the macro, `mem_we`=0xFF.

Source files
------------

// File: rtl/data_store.sv
// Data-load stage: pops decoder FIFO beats and writes them to the buffer SRAM from a programmed base.
// Optional DS_STRB_EN passes per-beat byte strobes to mem_we; otherwise every write is full-width.
module data_store #(
  parameter int TBITS  = 64,
  parameter int TBYTE  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_empty_n,
  output logic              ds_read,
  input  logic [TBITS-1:0]  fifo_data_din,
  input  logic [TBYTE-1:0]  fifo_strb_din,
  input  logic              fifo_last_din,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   wr_limit,
  output logic              mem_en,
  output logic [TBYTE-1:0]  mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [TBITS-1:0]  mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              ovf_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_word_cnt;
  logic                r_ovf;
  logic                r_mem_en;
  logic [TBYTE-1:0]    r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [TBITS-1:0]    r_mem_wdata;

  logic                w_beat;
  logic                w_room;
  logic                w_store;
  logic [TBYTE-1:0]    w_strb;

`ifdef DS_STRB_EN
  assign w_strb = fifo_strb_din;
`else
  logic w_unused_strb;
  assign w_unused_strb = ^fifo_strb_din;
  assign w_strb        = '1;
`endif

  assign w_beat  = (r_state == S_LOAD) && ds_empty_n;
  assign w_room  = (wr_limit == '0) || (r_word_cnt < wr_limit);
  assign w_store = w_beat && w_room;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_word_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_store;
      r_mem_we <= w_store ? w_strb : '0;
      if (w_store) begin
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= fifo_data_din;
      end

      case (r_state)
        S_IDLE: begin
          if (ds_empty_n) begin
            r_ptr      <= base_addr;
            r_word_cnt <= '0;
            r_ovf      <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            if (w_room) begin
              r_ptr <= r_ptr + 1'b1;
              if (r_word_cnt != '1)
                r_word_cnt <= r_word_cnt + 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
            // Last beat ends the load even when it was discarded over the limit.
            if (fifo_last_din)
              r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ds_read   = (r_state == S_LOAD);
  assign load_busy = (r_state == S_LOAD);
  assign load_done = (r_state == S_DONE);
  assign word_cnt  = r_word_cnt;
  assign ovf_err   = r_ovf;

  // Reset in the cycle a write is on the bus cancels that write.
  assign mem_en    = r_mem_en & ~reset;
  assign mem_we    = r_mem_we & {TBYTE{~reset}};
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
